// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two level-request ports (IDLE -> ACCESS -> RESP).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to port 0.
module ram_arbiter #(
   parameter int addressWidth = 4,
   parameter int dataWidth    = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   // port 0
   input  logic                    req0,
   input  logic                    we0,
   input  logic [addressWidth-1:0] addr0,
   input  logic [dataWidth-1:0]    wdata0,
   output logic                    ack0,
   // port 1
   input  logic                    req1,
   input  logic                    we1,
   input  logic [addressWidth-1:0] addr1,
   input  logic [dataWidth-1:0]    wdata1,
   output logic                    ack1,
   // shared results / status
   output logic [dataWidth-1:0]    rdata,
   output logic                    busy,
   // RAM side
   output logic [addressWidth-1:0] ram_addr,
   inout  wire  [dataWidth-1:0]    ram_data,
   output logic                    ram_oe,
   output logic                    ram_we,
   // debug visibility of the sequencer
   output logic [1:0]              state_dbg
);

   // Handshake: reqN is a level held by the requester until ackN; ackN is a
   // one-cycle pulse.  reqN is only sampled in IDLE, and the requester must drop
   // it in its ack cycle, otherwise it is taken as a fresh request.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    last_grant;
   logic                    we_q;
   logic [addressWidth-1:0] addr_q;
   logic [dataWidth-1:0]    wdata_q;
   logic                    grant_any;
   logic                    grant_sel;

   // Arbitration: grant_sel is the winning port when grant_any is set.
   always_comb begin
      grant_any = req0 | req1;
      grant_sel = 1'b0;
      if (req0 && req1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
         grant_sel = ~last_grant;
`else
         grant_sel = 1'b0;
`endif
      end else begin
         grant_sel = req1;
      end
   end

   // Next state and outputs; last_grant doubles as the port currently served.
   always_comb begin
      state_nxt = state;
      ack0      = 1'b0;
      ack1      = 1'b0;
      ram_oe    = 1'b0;
      ram_we    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any) state_nxt = ACCESS;
         end
         ACCESS: begin
            state_nxt = RESP;
            ram_oe    = ~we_q;
            ram_we    = we_q;
         end
         RESP: begin
            state_nxt = IDLE;
            ack0      = ~last_grant;
            ack1      = last_grant;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata      <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && grant_any) begin
            last_grant <= grant_sel;
            we_q       <= grant_sel ? we1    : we0;
            addr_q     <= grant_sel ? addr1  : addr0;
            wdata_q    <= grant_sel ? wdata1 : wdata0;
         end
         // Read data is captured on the edge that ends the ACCESS cycle.
         if (state == ACCESS && !we_q) rdata <= ram_data;
      end
   end

   assign ram_addr  = addr_q;
   assign ram_data  = ram_we ? wdata_q : {dataWidth{1'bz}};
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   a_oe_we_excl: assert property (@(posedge clk) !(ram_oe && ram_we));
   a_ack_excl:   assert property (@(posedge clk) !(ack0 && ack1));

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a behavioural RAM on the shared bus.
// Expected arbitration pattern follows RAM_ARB_ROUND_ROBIN_EN when defined.
module tb_ram_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, busy, ram_oe, ram_we;
   logic [DW-1:0] rdata;
   logic [AW-1:0] ram_addr;
   logic [1:0]    state_dbg;
   wire  [DW-1:0] ram_data;

   logic [DW-1:0] mem [0:15];
   logic          preload;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_rd;
   int            n_cmp = 0;
   int            n_bad = 0;

   // ---------------- clock / DUT / RAM model ----------------
   always #5 clk = ~clk;

   ram_arbiter #(.addressWidth(AW), .dataWidth(DW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .busy(busy),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_oe(ram_oe), .ram_we(ram_we),
      .state_dbg(state_dbg)
   );

   // An undriven bus floats high, so a released bus reads 8'hFF.
   pullup (ram_data);
   assign ram_data = ram_oe ? mem[ram_addr] : 'z;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      end else if (ram_we) begin
         mem[ram_addr] <= ram_data;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Bus rules checked every cycle away from the active edge.
   always @(negedge clk) begin
      if (!preload) begin
         check("oe_we_excl", {31'd0, ram_oe & ram_we}, 32'd0);
         if (!ram_oe && !ram_we) check("bus_released", {24'd0, ram_data}, 32'hFF);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction on a single port, checked cycle by cycle.
   task automatic xfer(input int port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
      logic [DW-1:0] exp_rd;
      if (port == 0) begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end
      tick();  // granting edge -> ACCESS
      // requester inputs are free to change once granted
      we0 = ~we; addr0 = ~addr; wdata0 = ~wdata;
      we1 = ~we; addr1 = ~addr; wdata1 = ~wdata;
      check("acc_busy",  busy, 1);
      check("acc_state", state_dbg, 1);
      check("acc_oe",    ram_oe, !we);
      check("acc_we",    ram_we, we);
      check("acc_addr",  ram_addr, addr);
      check("acc_ack",   {ack0, ack1}, 0);
      if (we) check("acc_bus", ram_data, wdata);
      tick();  // RESP
      check("resp_state", state_dbg, 2);
      check("resp_ack0",  ack0, port == 0);
      check("resp_ack1",  ack1, port == 1);
      check("resp_oe_we", {ram_oe, ram_we}, 0);
      if (!we) begin
         if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
            exp_rd = '0;
         end else begin
            exp_rd = exp_q.pop_front();
         end
         check("resp_rdata", rdata, exp_rd);
         last_rd = exp_rd;
      end else begin
         check("rdata_hold", rdata, last_rd);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();  // IDLE
      check("idle_busy", busy, 0);
      check("idle_ack",  {ack0, ack1}, 0);
      check("idle_we",   ram_we, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic exp_port;
      preload = 1'b1;
      reset = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      last_rd = '0;
      tick();
      tick();
      preload = 1'b0;
      check("rst_ack",   {ack0, ack1}, 0);
      check("rst_oe_we", {ram_oe, ram_we}, 0);
      check("rst_addr",  ram_addr, 0);
      check("rst_rdata", rdata, 0);
      check("rst_busy",  busy, 0);
      check("rst_state", state_dbg, 0);
      reset = 1'b0;
      tick();
      check("idle_noreq_busy", busy, 0);

      // port 0 write, then port 1 reads it back
      xfer(0, 1'b1, 4'h3, 8'hA5);
      exp_q.push_back(8'hA5);
      xfer(1, 1'b0, 4'h3, 8'h00);

      // continuous contention from reset (last_grant = 1)
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_rd = '0;
      req0 = 1; we0 = 0; addr0 = 4'h1;
      req1 = 1; we1 = 0; addr1 = 4'h2;
      for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
         exp_port = (i % 2) == 1;
`else
         exp_port = 1'b0;
`endif
         tick();  // ACCESS
         check("cont_addr", ram_addr, exp_port ? 4'h2 : 4'h1);
         tick();  // RESP
         check("cont_ack0",  ack0, !exp_port);
         check("cont_ack1",  ack1, exp_port);
         check("cont_rdata", rdata, exp_port ? 8'h12 : 8'h11);
         tick();  // IDLE
         check("cont_busy", busy, 0);
      end
      req0 = 0; req1 = 0;
      last_rd = exp_port ? 8'h12 : 8'h11;
      tick();

      // reset during the ACCESS cycle of a write to addr 5
      req0 = 1; we0 = 1; addr0 = 4'h5; wdata0 = 8'h77;
      tick();
      check("rstw_acc_we", ram_we, 1);
      reset = 1'b1;
      req0 = 1'b0;
      tick();
      check("rstw_ack",   {ack0, ack1}, 0);
      check("rstw_oe_we", {ram_oe, ram_we}, 0);
      check("rstw_busy",  busy, 0);
      check("rstw_bus",   ram_data, 8'hFF);
      reset = 1'b0;
      last_rd = '0;
      tick();
      check("rstw_noack", {ack0, ack1}, 0);
      check("rstw_idle",  busy, 0);
      exp_q.push_back(8'h10);
      xfer(0, 1'b0, 4'h0, 8'h00);

      // read-after-write over the whole address space
      for (int a = 0; a < 16; a++) begin
         xfer(0, 1'b1, 4'(a), 8'(a) ^ 8'h5A);
         exp_q.push_back(8'(a) ^ 8'h5A);
         xfer(1, 1'b0, 4'(a), 8'h00);
      end

      check("exp_q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
